// File: rtl/xs_bugcase_pkg.sv
// Shared types and constants for the ExprCastBug result-stream consumers.
package xs_bugcase_pkg;

  localparam int SUM_W     = 9;
  localparam int REP_ACC_W = 16;
  localparam int REP_CNT_W = 8;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } mon_state_t;

  // Widest report layout; narrower ACC_W / CNT_W instances zero-extend into it.
  typedef struct packed {
    logic [REP_ACC_W-1:0] acc;
    logic [SUM_W-1:0]     max;
    logic [REP_CNT_W-1:0] bad_cnt;
    logic                 overflow;
  } mon_report_t;

endpackage

// File: rtl/xs_sat_acc.sv
// Saturating unsigned accumulator with enable, clear and sticky overflow.
// acc_sum/ovf_sum show the result including the current din.
module xs_sat_acc
  import xs_bugcase_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [SUM_W-1:0] din,
  output logic [ACC_W-1:0] acc_sum,
  output logic             ovf_sum
);

  logic [ACC_W-1:0] acc_p0;
  logic             ovf_p0;
  logic             ovf_now;

  // Returns {saturated, value}; value pins at all-ones when the carry is lost.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [SUM_W-1:0] b);
    logic [ACC_W:0] wide;
    wide = {1'b0, a} + (ACC_W + 1)'(b);
    if (wide[ACC_W]) sat_add = {1'b1, {ACC_W{1'b1}}};
    else             sat_add = wide;
  endfunction

  assign {ovf_now, acc_sum} = sat_add(acc_p0, din);
  assign ovf_sum = ovf_p0 | ovf_now;

  // p0: running window accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0 <= '0;
      ovf_p0 <= 1'b0;
    end else if (clear) begin
      acc_p0 <= '0;
      ovf_p0 <= 1'b0;
    end else if (en) begin
      acc_p0 <= acc_sum;
      ovf_p0 <= ovf_sum;
    end
  end

endmodule

// File: rtl/xs_sum_window_monitor.sv
// Reduces WINDOW accepted (sum, bad) samples into one valid/ready report.
// Optional sticky_err output enabled by XS_SUM_WINDOW_MONITOR_STICKY_ERR_EN.
module xs_sum_window_monitor
  import xs_bugcase_pkg::*;
#(
  parameter int  WINDOW = 8,
  parameter int  ACC_W  = 16,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             in_bad,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [SUM_W-1:0] out_max,
  output logic [CNT_W-1:0] out_bad_cnt,
  output logic             out_overflow
`ifdef XS_SUM_WINDOW_MONITOR_STICKY_ERR_EN
  ,
  output logic             sticky_err
`endif
);

  mon_state_t       state_q, state_d;
  logic             accept_p0, last_p0;
  logic [CNT_W-1:0] cnt_p0, bad_p0, bad_next;
  logic [SUM_W-1:0] max_p0, max_next;
  logic [ACC_W-1:0] acc_sum;
  logic             ovf_sum;

  // in_ready is a registered copy of (state == ACCUM), so it gates acceptance directly.
  assign accept_p0 = in_valid & in_ready & ~clear;
  assign last_p0   = accept_p0 & (cnt_p0 == CNT_W'(WINDOW - 1));
  assign max_next  = (in_sum > max_p0) ? in_sum : max_p0;
  assign bad_next  = bad_p0 + CNT_W'(in_bad);

  xs_sat_acc #(.ACC_W(ACC_W)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear | last_p0),
    .en      (accept_p0),
    .din     (in_sum),
    .acc_sum (acc_sum),
    .ovf_sum (ovf_sum)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:  if (last_p0) state_d = REPORT;
      REPORT: if (out_ready) state_d = ACCUM;
    endcase
    if (clear) state_d = ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == ACCUM);
      out_valid <= (state_d == REPORT);
    end
  end

  // p0: working counters for the current window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
      max_p0 <= '0;
      bad_p0 <= '0;
    end else if (clear || last_p0) begin
      cnt_p0 <= '0;
      max_p0 <= '0;
      bad_p0 <= '0;
    end else if (accept_p0) begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
      max_p0 <= max_next;
      bad_p0 <= bad_next;
    end
  end

  // p1: report registers, loaded with results that include the final sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_acc      <= '0;
      out_max      <= '0;
      out_bad_cnt  <= '0;
      out_overflow <= 1'b0;
    end else if (last_p0) begin
      out_acc      <= acc_sum;
      out_max      <= max_next;
      out_bad_cnt  <= bad_next;
      out_overflow <= ovf_sum;
    end
  end

`ifdef XS_SUM_WINDOW_MONITOR_STICKY_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          sticky_err <= 1'b0;
    else if (clear)                                   sticky_err <= 1'b0;
    else if ((accept_p0 && in_bad) || (last_p0 && ovf_sum)) sticky_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_xs_sum_window_monitor.sv
// Directed plus randomized bench for xs_sum_window_monitor against a queue-based window model.
`timescale 1ns/1ps
module tb_xs_sum_window_monitor;
  import xs_bugcase_pkg::*;

  localparam int WIN   = 4;
  localparam int AW    = 10;
  localparam int CW    = $clog2(WIN + 1);
  localparam int AMAX  = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, in_bad, out_ready;
  logic          in_ready, out_valid, out_overflow;
  logic [8:0]    in_sum;
  logic [AW-1:0] out_acc;
  logic [8:0]    out_max;
  logic [CW-1:0] out_bad_cnt;
`ifdef XS_SUM_WINDOW_MONITOR_STICKY_ERR_EN
  logic          sticky_err;
`endif

  always #5 clk = ~clk;

  xs_sum_window_monitor #(.WINDOW(WIN), .ACC_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_bad       (in_bad),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_acc      (out_acc),
    .out_max      (out_max),
    .out_bad_cnt  (out_bad_cnt),
    .out_overflow (out_overflow)
`ifdef XS_SUM_WINDOW_MONITOR_STICKY_ERR_EN
    ,
    .sticky_err   (sticky_err)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          win_sum[$];
  int          win_bad[$];
  bit          pending = 1'b0;
  bit          exp_sticky = 1'b0;
  mon_report_t exp_rep = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Report derived from the whole window at once: saturation is min(total, max).
  task automatic build_report();
    int total, mx, nb;
    total = 0; mx = 0; nb = 0;
    foreach (win_sum[i]) begin
      total += win_sum[i];
      if (win_sum[i] > mx) mx = win_sum[i];
      nb += win_bad[i];
    end
    exp_rep.acc      = REP_ACC_W'((total > AMAX) ? AMAX : total);
    exp_rep.max      = SUM_W'(mx);
    exp_rep.bad_cnt  = REP_CNT_W'(nb);
    exp_rep.overflow = (total > AMAX);
    if (exp_rep.overflow) exp_sticky = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!pending));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(pending));
    if (pending) begin
      chk({tag, ".acc"}, 32'(out_acc), 32'(exp_rep.acc));
      chk({tag, ".max"}, 32'(out_max), 32'(exp_rep.max));
      chk({tag, ".bad_cnt"}, 32'(out_bad_cnt), 32'(exp_rep.bad_cnt));
      chk({tag, ".overflow"}, 32'(out_overflow), 32'(exp_rep.overflow));
    end
`ifdef XS_SUM_WINDOW_MONITOR_STICKY_ERR_EN
    chk({tag, ".sticky"}, 32'(sticky_err), 32'(exp_sticky));
`endif
  endtask

  task automatic step(input string tag, input bit v, input int s, input bit b,
                      input bit r, input bit c);
    in_valid = v; in_sum = 9'(s); in_bad = b; out_ready = r; clear = c;
    @(posedge clk);
    #1;
    if (c) begin
      win_sum.delete(); win_bad.delete();
      pending = 1'b0; exp_sticky = 1'b0;
    end else if (pending) begin
      if (r) pending = 1'b0;
    end else if (v) begin
      win_sum.push_back(s);
      win_bad.push_back(int'(b));
      if (b) exp_sticky = 1'b1;
      if (win_sum.size() == WIN) begin
        build_report();
        pending = 1'b1;
        win_sum.delete(); win_bad.delete();
      end
    end
    check_outputs(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_acc"}, 32'(out_acc), 32'd0);
    chk({tag, ".out_max"}, 32'(out_max), 32'd0);
    chk({tag, ".out_bad_cnt"}, 32'(out_bad_cnt), 32'd0);
    chk({tag, ".out_overflow"}, 32'(out_overflow), 32'd0);
`ifdef XS_SUM_WINDOW_MONITOR_STICKY_ERR_EN
    chk({tag, ".sticky"}, 32'(sticky_err), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = '0; in_bad = 1'b0; out_ready = 1'b0;
    #12;
    check_reset_values("reset");
    #1 rst = 1'b0;

    // Basic window
    step("t1", 1, 10, 0, 0, 0);
    step("t1", 1, 20, 1, 0, 0);
    step("t1", 1, 30, 0, 0, 0);
    step("t1", 1, 40, 1, 0, 0);
    chk("t1.acc_const", 32'(out_acc), 32'd100);
    chk("t1.max_const", 32'(out_max), 32'd40);
    chk("t1.bad_const", 32'(out_bad_cnt), 32'd2);
    chk("t1.valid_const", 32'(out_valid), 32'd1);

    // Backpressure: in_valid during REPORT must be ignored
    for (int i = 0; i < 5; i++) step("t2.hold", 1, 99, 1, 0, 0);
    chk("t2.acc_held", 32'(out_acc), 32'd100);
    step("t2.hs", 0, 0, 0, 1, 0);
    chk("t2.ready_after_hs", 32'(in_ready), 32'd1);

    // Saturation then a clean window
    for (int i = 0; i < 4; i++) step("t3.sat", 1, 511, 0, 0, 0);
    chk("t3.acc_const", 32'(out_acc), 32'd1023);
    chk("t3.ovf_const", 32'(out_overflow), 32'd1);
    step("t3.hs", 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("t3.small", 1, 1, 0, 0, 0);
    chk("t3.acc_small", 32'(out_acc), 32'd4);
    chk("t3.ovf_small", 32'(out_overflow), 32'd0);
    step("t3.hs2", 0, 0, 0, 1, 0);

    // Soft clear drops partial window and the same-cycle sample
    step("t4", 1, 5, 0, 0, 0);
    step("t4", 1, 6, 0, 0, 0);
    step("t4.clr", 1, 7, 0, 0, 1);
    for (int i = 1; i <= 4; i++) step("t4", 1, i, 0, 0, 0);
    chk("t4.acc_const", 32'(out_acc), 32'd10);
    chk("t4.max_const", 32'(out_max), 32'd4);
    step("t4.hs", 0, 0, 0, 1, 0);

    // Asynchronous reset while a report is pending
    for (int i = 0; i < 4; i++) step("t5.fill", 1, 100 + i, 1, 0, 0);
    step("t5.hold", 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t5.async_valid", 32'(out_valid), 32'd0);
    chk("t5.async_ready", 32'(in_ready), 32'd1);
    win_sum.delete(); win_bad.delete();
    pending = 1'b0; exp_sticky = 1'b0;
    check_reset_values("t5.reset");
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) step("t5.post", 1, 2, 0, 0, 0);
    chk("t5.acc_const", 32'(out_acc), 32'd8);
    step("t5.hs", 0, 0, 0, 1, 0);

    // Sticky error behaviour (checked by the model when the port exists)
    step("t6.clr", 0, 0, 0, 0, 1);
    step("t6.bad", 1, 3, 1, 0, 0);
`ifdef XS_SUM_WINDOW_MONITOR_STICKY_ERR_EN
    chk("t6.sticky_set", 32'(sticky_err), 32'd1);
`endif
    for (int i = 0; i < 3; i++) step("t6.fill", 1, 3, 0, 0, 0);
    step("t6.hs", 0, 0, 0, 1, 0);
`ifdef XS_SUM_WINDOW_MONITOR_STICKY_ERR_EN
    chk("t6.sticky_kept", 32'(sticky_err), 32'd1);
`endif
    step("t6.clr2", 0, 0, 0, 0, 1);
`ifdef XS_SUM_WINDOW_MONITOR_STICKY_ERR_EN
    chk("t6.sticky_clr", 32'(sticky_err), 32'd0);
`endif

    // Randomized traffic, biased toward large sums to hit saturation
    for (int i = 0; i < 400; i++) begin
      bit v, b, r, c;
      int s;
      v = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 40) == 0);
      s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(300, 511)) : int'($urandom_range(0, 511));
      step("rand", v, s, b, r, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xs_sum_window_monitor.md
Name: xs_sum_window_monitor

Overview:
- Downstream consumer of the ExprCastBug result stream (sum[8:0], bad).
- Collects WINDOW accepted samples and reduces them to one report per window:
  - saturating sum of the window
  - maximum sample
  - count of bad-flagged samples
  - overflow flag
- The report is presented through a valid/ready handshake to the next stage (scoreboard or trace sink).
- Input is back-pressured while a report is pending.

Parameters:
- WINDOW, 8, number of accepted samples per report; legal range 1..255.
- ACC_W, 16, accumulator and out_acc width; must be >= 9.
- CNT_W, derived localparam = $clog2(WINDOW+1), width of the sample counter and the bad counter.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous soft clear.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block can accept a sample.
- in_sum  input  9  upstream sum, unsigned.
- in_bad  input  1  upstream bad flag.
- out_valid  output  1  report valid.
- out_ready  input  1  downstream accepts the report.
- out_acc  output  ACC_W  saturating window sum.
- out_max  output  9  largest in_sum in the window.
- out_bad_cnt  output  CNT_W  number of samples with in_bad=1.
- out_overflow  output  1  accumulator saturated during the window.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=ACCUM, in_ready=1.
  - out_valid=0, out_acc=0, out_max=0, out_bad_cnt=0, out_overflow=0.
  - All working registers (acc, max, bad count, sample count, overflow) = 0.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - REPORT: in_ready=0, out_valid=1.
  - in_ready and out_valid are registered, not combinational.
- Accept: in_valid & in_ready at a rising edge. Upstream must hold in_sum and in_bad stable while in_valid=1 and in_ready=0.
- On each accept in ACCUM:
  - acc_next = acc + zero-extended in_sum. If the true result exceeds 2^ACC_W-1, acc holds 2^ACC_W-1 and overflow is set (sticky for the window).
  - max = max(max, in_sum), unsigned compare.
  - bad count += in_bad.
  - sample count += 1.
- Window end (accept with sample count == WINDOW-1):
  - The results that include this final sample are copied into the out_* registers.
  - Working registers clear to 0.
  - state -> REPORT; out_valid=1 and in_ready=0 from the next cycle. Latency from final accept to out_valid = 1 cycle.
- REPORT:
  - out_* are held stable until out_valid & out_ready.
  - On that edge: state -> ACCUM, out_valid=0, in_ready=1 next cycle.
  - out_* data keep their last values after the handshake; they are meaningless while out_valid=0.
  - There is no sample acceptance in the same cycle as the report handshake.
- WINDOW=1: every accept produces a report. Max throughput is then 1 sample per 2 cycles; for general WINDOW it is WINDOW samples per WINDOW+1 cycles.
- clear=1 at an edge (priority below rst, above everything else):
  - state -> ACCUM; working registers and sample count cleared.
  - out_valid -> 0; a pending report is discarded.
  - A sample offered in the same cycle is dropped, not accumulated.
- rst asserted mid-window or mid-REPORT: everything returns to reset values immediately; no partial report is emitted.
- out_ready is ignored in ACCUM. in_valid is ignored in REPORT.

Optional Feature:
- Macro: XS_SUM_WINDOW_MONITOR_STICKY_ERR_EN.
- Defined:
  - Adds output port sticky_err (1 bit, reset 0).
  - Set on the edge after any accepted sample with in_bad=1, or any window ending with overflow=1.
  - Cleared only by rst or clear.
- Not defined: port and logic absent; all other behaviour identical.

Decomposition:
- Package xs_bugcase_pkg:
  - SUM_W=9 constant.
  - mon_state_t enum {ACCUM, REPORT}.
  - mon_report_t packed struct {acc, max, bad_cnt, overflow}, ACC_W-independent fields parameterised via localparams.
- Sub-module xs_sat_acc:
  - Saturating adder/accumulator with enable, clear and sticky overflow output.
  - Parameter ACC_W; instantiated once.
- Max and bad counters stay inline.

Test Plan:
1. Basic window. WINDOW=4; accept sums 10,20,30,40 with bad 0,1,0,1 back-to-back.
   - One cycle after the 4th accept: out_valid=1, out_acc=100, out_max=40, out_bad_cnt=2, out_overflow=0, in_ready=0.
2. Backpressure. Continue from test 1 with out_ready=0 for 5 cycles, then 1.
   - out_* stable and in_ready=0 for all 5 cycles.
   - Handshake on cycle 6; in_ready=1 on cycle 7.
3. Saturation. ACC_W=10, WINDOW=4; sums 511,511,511,511.
   - out_acc=1023, out_max=511, out_overflow=1.
   - Next window of 1,1,1,1 reports acc=4, overflow=0.
4. Soft clear. WINDOW=4; accept 5,6, then clear with in_valid=1 and sum 7, then accept 1,2,3,4.
   - Report acc=10, max=4; the values 5, 6 and 7 are absent.
5. Reset mid-REPORT. Hold the report with out_ready=0, then pulse rst asynchronously between edges.
   - out_valid=0 and in_ready=1 immediately.
   - The next report reflects only post-reset samples.
6. With XS_SUM_WINDOW_MONITOR_STICKY_ERR_EN defined:
   - A single bad=1 sample sets sticky_err on the following edge.
   - sticky_err survives the report handshake.
   - clear drops sticky_err to 0.
